io_sched: RTL

- Sequencing and I/O-buffering controller between streaming sample sources/sinks and the proc_fl soft processor.
- Buffers each input port in a small FIFO and serves the processor's one-hot req_in read strobes from it.
- Captures processor writes, strobed by out_en, into per-port sink registers.
- Holds the processor idle (proc_run low) until the enabled input FIFOs are primed.

---
 rtl/io_sched_pkg.sv | 27 ++
 rtl/io_sched_fifo.sv | 58 +++++
 rtl/io_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/io_sched_pkg.sv
// Shared types and helpers for the io_sched sequencing / I/O-buffering controller.
package io_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/io_sched_fifo.sv
// Single-port-pair sample FIFO with flush; head is the combinational front entry.
module io_sched_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_sched.sv
// Sequencing and I/O buffering between sample streams and the proc_fl processor.
// Define IO_SCHED_UNDERFLOW_HALT_EN to halt the processor on an underflow in RUN.
module io_sched
  import io_sched_pkg::*;
#(
  parameter int NPORT     = 4,
  parameter int DW_IN     = 19,
  parameter int DW_OUT    = 28,
  parameter int FDEPTH    = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NPORT-1:0]        port_mask,
  input  logic                    clr_status,
  input  logic [NPORT*DW_IN-1:0]  src_data,
  input  logic [NPORT-1:0]        src_valid,
  output logic [NPORT-1:0]        src_ready,
  input  logic [NPORT-1:0]        req_in,
  output logic [DW_IN-1:0]        io_in,
  input  logic [NPORT-1:0]        out_en,
  input  logic [DW_OUT-1:0]       io_out,
  output logic [NPORT*DW_OUT-1:0] snk_data,
  output logic [NPORT-1:0]        snk_valid,
  output logic                    proc_run,
  output logic [NPORT-1:0]        underflow,
  output logic                    multi_req,
  output logic [STATE_W-1:0]      state
);

  localparam int CW = $clog2(FDEPTH) + 1;
  localparam int SW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LVL);

  logic [DW_IN-1:0]  head  [NPORT];
  logic [CW-1:0]     count [NPORT];
  logic [DW_IN-1:0]  hold  [NPORT];
  logic [DW_OUT-1:0] snk_q [NPORT];
  logic [NPORT-1:0]  full, empty, push, pop, uf_evt, cnt_ok;
  logic [SW-1:0]     rd_sel, wr_sel;
  logic              flush;
  state_t            state_q, state_d;

  assign rd_sel = SW'(lowest_set(32'(req_in)));
  assign wr_sel = SW'(lowest_set(32'(out_en)));
  assign state  = state_q;

  for (genvar k = 0; k < NPORT; k++) begin : g_port
    assign push[k]      = src_valid[k] & ~full[k];
    assign src_ready[k] = ~full[k];
    assign cnt_ok[k]    = ~port_mask[k] | (count[k] >= PRIME_CNT);
    assign snk_data[k*DW_OUT +: DW_OUT] = snk_q[k];

    io_sched_fifo #(.DW(DW_IN), .DEPTH(FDEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[k]),
      .din   (src_data[k*DW_IN +: DW_IN]),
      .pop   (pop[k]),
      .head  (head[k]),
      .count (count[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Reads never bypass a same-cycle push: an empty FIFO returns the last popped value.
  always_comb begin
    pop    = '0;
    uf_evt = '0;
    io_in  = '0;
    if (|req_in) begin
      if (empty[rd_sel]) begin
        io_in          = hold[rd_sel];
        uf_evt[rd_sel] = 1'b1;
      end else begin
        io_in       = head[rd_sel];
        pop[rd_sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPORT; k++) hold[k] <= '0;
      underflow <= '0;
      multi_req <= 1'b0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (pop[k]) hold[k] <= head[k];
      end
      underflow <= (clr_status ? '0 : underflow) | uf_evt;
      multi_req <= (~clr_status & multi_req) | multi_hot(32'(req_in)) | multi_hot(32'(out_en));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPORT; k++) snk_q[k] <= '0;
      snk_valid <= '0;
    end else begin
      snk_valid <= '0;
      if (|out_en) begin
        snk_q[wr_sel]     <= io_out;
        snk_valid[wr_sel] <= 1'b1;
      end
    end
  end

  // Flush happens only on the edge that enters IDLE, so data pushed while idle is kept.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable)      state_d = IDLE;
        else if (&cnt_ok) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = IDLE;
`ifdef IO_SCHED_UNDERFLOW_HALT_EN
        else if (|uf_evt) state_d = HALT;
`endif
      end
      HALT: begin
        if (!enable)         state_d = IDLE;
        else if (clr_status) state_d = PRIME;
      end
      default: state_d = IDLE;
    endcase
    flush = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      proc_run <= 1'b0;
    end else begin
      state_q  <= state_d;
      proc_run <= (state_d == RUN);
    end
  end

endmodule
